// File: rtl/acc_alu_pkg.sv
// Shared op encodings and op-class definitions for the accumulate ALU.
// The stage-1 datapath and the accumulator both decode ops through this package.
package acc_alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // ADD and MUL share one class: both fold an unsigned term upward into the accumulator.
    typedef enum logic [1:0] {
        CLS_ADD  = 2'b00,
        CLS_SUB  = 2'b01,
        CLS_LOAD = 2'b10
    } op_class_e;

    function automatic op_class_e op_class(input logic [1:0] sel);
        case (sel)
            OP_SUB:  return CLS_SUB;
            OP_LOAD: return CLS_LOAD;
            default: return CLS_ADD;
        endcase
    endfunction

endpackage

// File: rtl/acc_op_unit.sv
// Combinational stage-1 datapath: forms the 2*IN_W-bit term and its op class.
// Every op except MUL uses the plain sum a+b.
module acc_op_unit
    import acc_alu_pkg::*;
#(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]   a_i,
    input  logic [IN_W-1:0]   b_i,
    input  logic [1:0]        sel_i,
    output logic [2*IN_W-1:0] t_o,
    output op_class_e         cls_o
);

    logic [2*IN_W-1:0] a_ext;
    logic [2*IN_W-1:0] b_ext;

    assign a_ext = {{IN_W{1'b0}}, a_i};
    assign b_ext = {{IN_W{1'b0}}, b_i};

    assign t_o   = (sel_i == OP_MUL) ? a_ext * b_ext : a_ext + b_ext;
    assign cls_o = op_class(sel_i);

endmodule

// File: rtl/acc_alu_param.sv
// Two-stage accumulate ALU: stage 1 registers the op term, stage 2 folds it into
// an ACC_W-bit accumulator with wrap or saturate, a sticky flag and a sample count.
module acc_alu_param
    import acc_alu_pkg::*;
#(
    parameter int IN_W     = 3,
    parameter int ACC_W    = 6,
    parameter bit SATURATE = 1'b0,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_data1,
    input  logic [IN_W-1:0]  i_data2,
    input  logic [1:0]       i_sel,
    input  logic             i_clear,
    output logic [ACC_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_count
);

    if (ACC_W < 2 * IN_W) begin : g_bad_width
        $error("acc_alu_param: ACC_W must be at least 2*IN_W");
    end

    logic [2*IN_W-1:0] op_t;
    op_class_e         op_cls;

    acc_op_unit #(.IN_W(IN_W)) u_op (
        .a_i   (i_data1),
        .b_i   (i_data2),
        .sel_i (i_sel),
        .t_o   (op_t),
        .cls_o (op_cls)
    );

    logic              s1_valid_q;
    logic [2*IN_W-1:0] s1_t_q;
    op_class_e         s1_cls_q;

    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic              ovf_q,   ovf_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              valid_q, valid_d;

    // Stage 1 ignores i_clear so a sample arriving with the clear survives it.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_t_q     <= '0;
            s1_cls_q   <= CLS_ADD;
        end else begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_t_q   <= op_t;
                s1_cls_q <= op_cls;
            end
        end
    end

    logic [ACC_W:0] t_ext;
    logic [ACC_W:0] sum;
    logic [ACC_W:0] diff;

    assign t_ext = {{(ACC_W + 1 - 2 * IN_W){1'b0}}, s1_t_q};
    assign sum   = {1'b0, acc_q} + t_ext;
    assign diff  = {1'b0, acc_q} - t_ext;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (i_clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (s1_valid_q) begin
            valid_d = 1'b1;
            case (s1_cls_q)
                CLS_LOAD: begin
                    acc_d = t_ext[ACC_W-1:0];
                    cnt_d = CNT_W'(1);
                end
                CLS_SUB: begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (diff[ACC_W]) begin
                        ovf_d = 1'b1;
                        acc_d = SATURATE ? '0 : diff[ACC_W-1:0];
                    end else begin
                        acc_d = diff[ACC_W-1:0];
                    end
                end
                default: begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (sum[ACC_W]) begin
                        ovf_d = 1'b1;
                        acc_d = SATURATE ? '1 : sum[ACC_W-1:0];
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_data     = acc_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;
    assign o_count    = cnt_q;

endmodule

// File: doc/acc_alu_param.md
Name: acc_alu_param

Overview:
Parametrised two-operand arithmetic accumulator, the generalised successor of the 3-bit select/overflow exercise block. Each accepted sample is combined by an op selected with i_sel, then folded into an ACC_W-bit accumulator. Wrap or saturate behaviour is chosen by parameter. Provides a sticky overflow flag, a sample counter and a valid strobe. It sits in the unit-1 datapath exercises as a reusable accumulate stage fed by testbench or upstream logic.

Parameters:
IN_W, 3, operand width (unsigned), >=1
ACC_W, 6, accumulator width; must satisfy ACC_W >= 2*IN_W
SATURATE, 0, 0 = modulo-2^ACC_W wrap, 1 = clamp to [0, 2^ACC_W-1]
CNT_W, 4, sample counter width

Ports:
clk  in  1  single clock, all state on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  sample strobe; operands/sel sampled when high
i_data1  in  IN_W  operand a
i_data2  in  IN_W  operand b
i_sel  in  2  op: 00 ADD, 01 MUL, 10 SUB, 11 LOAD
i_clear  in  1  synchronous clear of accumulator, flag, counter
o_data  out  ACC_W  accumulator value
o_valid  out  1  one-cycle pulse: o_data just updated
o_overflow  out  1  sticky over/underflow flag
o_count  out  CNT_W  samples accumulated since clear (saturating)

Behaviour:
- Interface: one clock (clk); reset i_rst is asynchronous and active-high.
- Reset (async, any time, including mid-pipeline): o_data=0, o_valid=0, o_overflow=0, o_count=0, stage-1 valid=0. In-flight samples are lost.
- Stage 1 (edge k, i_valid=1): register t and the op class.
  - ADD: t=a+b. MUL: t=a*b. SUB: t=a+b. LOAD: t=a+b.
  - t is 2*IN_W bits, zero-extended.
- Stage 2 (edge k+1, stage-1 valid): compute in ACC_W+1 bits.
  - ADD/MUL: s=acc+t. SUB: s=acc-t. LOAD: acc=t.
  - Out of range means s > 2^ACC_W-1 (add) or s < 0 (sub).
  - Out of range sets o_overflow=1 (sticky). Wrap mode: acc=s mod 2^ACC_W. Saturate mode: acc=max or acc=0.
  - LOAD never sets the flag and never clears it.
- o_valid=1 for exactly the cycle after each stage-2 update. Latency from sample edge to o_valid: 2 cycles. Throughput is 1 sample/cycle with no stalls.
- o_count increments on each ADD/MUL/SUB update, saturating at 2^CNT_W-1. LOAD sets o_count=1.
- i_clear=1 at an edge: acc=0, o_overflow=0, o_count=0, o_valid=0 next cycle.
  - The pending stage-2 update is discarded.
  - A sample with i_valid=1 in the same cycle is still captured into stage 1. It becomes the first sample after the clear.
- i_valid=0: stage 1 goes invalid; acc holds; o_valid=0.
- i_sel and operands are don't-care when i_valid=0.

Decomposition:
- Package acc_alu_pkg holds op encodings OP_ADD=2'b00, OP_MUL=2'b01, OP_SUB=2'b10, OP_LOAD=2'b11, plus the op-class constants.
- Sub-module acc_op_unit: the combinational stage-1 op datapath (IN_W in, 2*IN_W out). The registers, accumulate and saturation logic live in the top.
- Elaboration check fails if ACC_W < 2*IN_W.

Test Plan (IN_W=3, ACC_W=6, CNT_W=4):
1. Reset and idle:
   - Assert i_rst mid-cycle with no clock edge → all outputs 0 immediately.
   - Release, idle 5 cycles → o_valid stays 0.
2. ADD stream, SATURATE=0:
   - a=1, b=1, sel=00 for 32 consecutive cycles → o_data 2,4,…,62, then 0 on the 32nd update.
   - o_overflow rises with that update; o_count=15 (saturated).
   - o_valid is high 2 cycles after each sample.
3. MUL and SATURATE=1:
   - a=7, b=7, sel=01 twice → 49, then 63 with o_overflow=1.
   - Same stimulus with SATURATE=0 → 49, then 34 with o_overflow=1.
4. SUB underflow:
   - After clear, a=1, b=0, sel=10 → wrap: o_data=63, flag=1; saturate: o_data=0, flag=1.
5. LOAD and clear:
   - LOAD a=5, b=2 → o_data=7, o_count=1, flag unchanged.
   - i_clear with i_valid=1 (ADD a=3, b=0) in the same cycle as an in-flight ADD → in-flight sample discarded.
   - Next o_data=3, o_count=1, flag=0.
6. Reset mid-pipeline:
   - Assert i_rst between sample edge and update edge → no o_valid pulse; o_data stays 0 after release.
